mem_bist_ctrl: RTL and testbench
================================

MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, RAM address width.
REQ-002 SHALL have parameter WORD_W, default 8, RAM word width.
REQ-003 SHALL have parameter DEPTH, default 1024, number of words tested (DEPTH = 2**ADDR_W).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  begin test; sampled only in IDLE.
REQ-007 pat_sel  input  1  pattern: 0 = (2*addr) mod 2**WORD_W, 1 = bitwise inverse of that value.
REQ-008 ram_addr  output  ADDR_W  RAM address.
REQ-009 ram_data_in  output  WORD_W  RAM write data.
REQ-010 ram_wr  output  1  RAM write strobe (1 = write, 0 = read).
REQ-011 ram_cs  output  1  RAM chip select.
REQ-012 ram_data_out  input  WORD_W  RAM read data, valid one cycle after read issue.
REQ-013 busy  output  1  test in progress.
REQ-014 done  output  1  test finished; held until next accepted start.
REQ-015 pass  output  1  meaningful only while done=1; 1 = zero mismatches.
REQ-016 err_count  output  ADDR_W+1  number of mismatching words.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE, READ, DRAIN.
REQ-018 IDLE: start=1 -> WRITE next cycle, with ram_addr=0, done=0, err_count=0, pattern latched from pat_sel.
REQ-019 WRITE: each cycle drive ram_cs=1, ram_wr=1, ram_data_in=pattern(ram_addr), then increment ram_addr; after address DEPTH-1 -> READ with ram_addr=0.
REQ-020 READ: each cycle drive ram_cs=1, ram_wr=0, increment ram_addr; after address DEPTH-1 -> DRAIN.
REQ-021 SHALL compare ram_data_out against pattern(address issued in the previous cycle) in every cycle following a READ cycle; on mismatch, increment err_count.
REQ-022 DRAIN: perform the final compare, drive ram_cs=0, ram_wr=0, then -> IDLE with done=1 and pass=(err_count==0 including the final compare).
REQ-023 Latency from start accepted to done=1 SHALL be exactly 2*DEPTH+2 cycles (2050 at defaults).
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 busy SHALL be 1 in WRITE, READ, and DRAIN, and 0 otherwise.
REQ-026 In IDLE, ram_cs=0 and ram_wr=0 SHALL hold.
REQ-027 Address counter SHALL wrap only via explicit state transition, never beyond DEPTH-1.
REQ-028 err_count SHALL saturate at all-ones.
REQ-029 The latched pattern select SHALL NOT change mid-test.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, ram_cs=0, ram_wr=0, ram_addr=0, ram_data_in=0, busy=0, done=0, pass=0, err_count=0, and log outputs to 0, including when rst occurs mid-test.
REQ-031 First start after reset release SHALL be accepted on the first rising edge with rst=0.

Configuration
REQ-032 Macro MEM_BIST_ERR_LOG_EN defined: SHALL add outputs first_err_addr (ADDR_W), first_err_data (WORD_W), and first_err_valid (1), capturing address and read data of the first mismatch per test; these outputs clear on accepted start.
REQ-033 Macro undefined: those ports and registers SHALL NOT exist; all other behaviour is identical.

Structure
REQ-034 Package mem_bist_pkg SHALL hold ADDR_W/WORD_W/DEPTH defaults and the FSM state enum.
REQ-035 Pattern function SHALL be in sub-module mem_bist_pattern (inputs addr and pat_sel; output expected word), instantiated twice: write-data and compare.

Verification
REQ-036 Fault-free RAM model, pat_sel=0, start pulse -> done=1 after 2050 cycles, pass=1, err_count=0, addr 3 written 0x06, addr 200 written 0x90.
REQ-037 pat_sel=1 -> addr 3 written 0xF9, pass=1.
REQ-038 RAM model with bit 0 stuck-at-1 at addr 5 -> err_count=1, pass=0; with MEM_BIST_ERR_LOG_EN: first_err_addr=5, first_err_data=0x0B.
REQ-039 start re-pulsed at cycle 100 of a test -> ignored; done still at cycle 2050.
REQ-040 rst asserted during WRITE at addr 300 -> ram_wr=0, ram_cs=0, busy=0 with no clock edge; new start -> full 2050-cycle test.
REQ-041 Back-to-back: start in cycle after done -> done drops, err_count cleared, second test completes identically.

Source files
------------

// File: rtl/mem_bist_pkg.sv
// Shared defaults and FSM state encoding for the memory BIST controller.
package mem_bist_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_WORD_W = 8;
  localparam int DEF_DEPTH  = 2**DEF_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } bist_state_e;

endpackage

// File: rtl/mem_bist_pattern.sv
// Test pattern generator: (2*addr) mod 2**WORD_W, optionally bit-inverted.
module mem_bist_pattern
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              pat_sel,
  output logic [WORD_W-1:0] expected
);

  logic [ADDR_W:0]   doubled;
  logic [WORD_W-1:0] base;

  assign doubled  = {addr, 1'b0};
  assign base     = WORD_W'(doubled);
  assign expected = pat_sel ? ~base : base;

endmodule

// File: rtl/mem_bist_ctrl.sv
// March-style write-then-read BIST controller for a synchronous single-port RAM.
// Optional first-mismatch log enabled by defining MEM_BIST_ERR_LOG_EN.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORD_W = DEF_WORD_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pat_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_data_in,
  output logic              ram_wr,
  output logic              ram_cs,
  input  logic [WORD_W-1:0] ram_data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
`ifdef MEM_BIST_ERR_LOG_EN
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [WORD_W-1:0] first_err_data,
  output logic              first_err_valid,
`endif
  output logic [ADDR_W:0]   err_count
);

  bist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cmp_addr_q;
  logic              cmp_pending_q;
  logic              pat_q;
  logic [WORD_W-1:0] wr_word, cmp_word;
  logic              last_addr, accept, mismatch;
  logic [ADDR_W:0]   err_next;

  mem_bist_pattern #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_wr_pat (
    .addr     (addr_q),
    .pat_sel  (pat_q),
    .expected (wr_word)
  );

  mem_bist_pattern #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_cmp_pat (
    .addr     (cmp_addr_q),
    .pat_sel  (pat_q),
    .expected (cmp_word)
  );

  assign last_addr   = (addr_q == ADDR_W'(DEPTH - 1));
  // Read data arrives the cycle after the read issue, so compare against the delayed address.
  assign mismatch    = cmp_pending_q && (ram_data_out != cmp_word);
  assign err_next    = (mismatch && (err_count != '1)) ? err_count + (ADDR_W+1)'(1) : err_count;
  assign ram_addr    = addr_q;
  assign ram_data_in = ram_wr ? wr_word : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ram_cs  = 1'b0;
    ram_wr  = 1'b0;
    busy    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept  = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        ram_cs = 1'b1;
        ram_wr = 1'b1;
        if (last_addr) state_d = ST_READ;
      end
      ST_READ: begin
        ram_cs = 1'b1;
        if (last_addr) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q        <= '0;
      cmp_addr_q    <= '0;
      cmp_pending_q <= 1'b0;
      pat_q         <= 1'b0;
      err_count     <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      cmp_pending_q <= (state_q == ST_READ);
      cmp_addr_q    <= addr_q;
      err_count     <= accept ? '0 : err_next;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q <= '0;
            pat_q  <= pat_sel;
            done   <= 1'b0;
            pass   <= 1'b0;
          end
        end
        ST_WRITE, ST_READ: addr_q <= last_addr ? '0 : addr_q + 1'b1;
        ST_DRAIN: begin
          addr_q <= '0;
          done   <= 1'b1;
          pass   <= (err_next == '0);
        end
        default: addr_q <= '0;
      endcase
    end
  end

`ifdef MEM_BIST_ERR_LOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_addr  <= '0;
      first_err_data  <= '0;
      first_err_valid <= 1'b0;
    end else if (accept) begin
      first_err_addr  <= '0;
      first_err_data  <= '0;
      first_err_valid <= 1'b0;
    end else if (mismatch && !first_err_valid) begin
      first_err_addr  <= cmp_addr_q;
      first_err_data  <= ram_data_out;
      first_err_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Scoreboard bench for mem_bist_ctrl with a stuck-bit RAM model and randomized patterns/faults.
module tb_mem_bist_ctrl;

  localparam int ADDR_W = 10;
  localparam int WORD_W = 8;
  localparam int DEPTH  = 1024;
  localparam int LAT    = 2*DEPTH + 2;

  logic              clk = 1'b0;
  logic              rst, start, pat_sel;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_data_in;
  logic [WORD_W-1:0] ram_data_out = '0;
  logic              ram_wr, ram_cs, busy, done, pass;
  logic [ADDR_W:0]   err_count;
`ifdef MEM_BIST_ERR_LOG_EN
  logic [ADDR_W-1:0] first_err_addr;
  logic [WORD_W-1:0] first_err_data;
  logic              first_err_valid;
`endif

  typedef struct {
    int unsigned start_cyc;
    int unsigned err;
    bit          pass;
    bit          pat;
    bit          fe_valid;
    int unsigned fe_addr;
    int unsigned fe_data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  bit          test_pat = 1'b0;
  logic        done_q = 1'b0;

  logic [WORD_W-1:0] mem [DEPTH];
  bit                fault_en  [DEPTH];
  int unsigned       fault_bit [DEPTH];
  bit                fault_val [DEPTH];

  mem_bist_ctrl #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .pat_sel         (pat_sel),
    .ram_addr        (ram_addr),
    .ram_data_in     (ram_data_in),
    .ram_wr          (ram_wr),
    .ram_cs          (ram_cs),
    .ram_data_out    (ram_data_out),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
`ifdef MEM_BIST_ERR_LOG_EN
    .first_err_addr  (first_err_addr),
    .first_err_data  (first_err_data),
    .first_err_valid (first_err_valid),
`endif
    .err_count       (err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference pattern from the arithmetic definition
  function automatic int unsigned pat_word(int unsigned a, bit p);
    int unsigned w;
    w = (2 * a) % (1 << WORD_W);
    return p ? ((1 << WORD_W) - 1 - w) : w;
  endfunction

  function automatic int unsigned faulty(int unsigned a, int unsigned w);
    if (!fault_en[a]) return w;
    return fault_val[a] ? (w | (1 << fault_bit[a])) : (w & ~(32'd1 << fault_bit[a]));
  endfunction

  function automatic exp_t model(bit p, int unsigned sc);
    exp_t e;
    e.start_cyc = sc; e.pat = p; e.err = 0;
    e.fe_valid = 1'b0; e.fe_addr = 0; e.fe_data = 0;
    for (int unsigned a = 0; a < DEPTH; a++) begin
      if (faulty(a, pat_word(a, p)) != pat_word(a, p)) begin
        if (!e.fe_valid) begin
          e.fe_valid = 1'b1; e.fe_addr = a; e.fe_data = faulty(a, pat_word(a, p));
        end
        if (e.err < (1 << (ADDR_W + 1)) - 1) e.err++;
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  // Synchronous RAM: read data one cycle after issue, stuck bits applied on read
  always @(posedge clk) begin
    if (ram_cs && ram_wr) mem[ram_addr] <= ram_data_in;
    if (ram_cs && !ram_wr)
      ram_data_out <= WORD_W'(faulty(int'(ram_addr), int'(mem[ram_addr])));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Write-data monitor and idle strobe monitor
  always @(negedge clk) begin
    if (!rst && ram_cs && ram_wr)
      check("wr_data", 64'(ram_data_in), 64'(pat_word(int'(ram_addr), test_pat)));
    if (!rst && !busy)
      check("idle_ram_ctl", 64'({ram_cs, ram_wr}), 64'(0));
  end

  // Completion monitor: pops one expectation per rising done
  always @(negedge clk) begin
    if (!rst && done && !done_q) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no completion at cycle %0d", cyc);
      end else begin
        int unsigned bad;
        mon_e = exp_q.pop_front();
        check("latency", 64'(cyc - mon_e.start_cyc), 64'(LAT));
        check("pass", 64'(pass), 64'(mon_e.pass));
        check("err_count", 64'(err_count), 64'(mon_e.err));
        check("busy_after_done", 64'(busy), 64'(0));
        bad = 0;
        for (int unsigned a = 0; a < DEPTH; a++)
          if (int'(mem[a]) != pat_word(a, mon_e.pat)) bad++;
        check("mem_image_bad_words", 64'(bad), 64'(0));
`ifdef MEM_BIST_ERR_LOG_EN
        check("first_err_valid", 64'(first_err_valid), 64'(mon_e.fe_valid));
        if (mon_e.fe_valid) begin
          check("first_err_addr", 64'(first_err_addr), 64'(mon_e.fe_addr));
          check("first_err_data", 64'(first_err_data), 64'(mon_e.fe_data));
        end
`endif
      end
    end
    done_q = rst ? 1'b0 : done;
  end

  task automatic clear_faults();
    for (int unsigned a = 0; a < DEPTH; a++) fault_en[a] = 1'b0;
  endtask

  task automatic add_fault(input int unsigned a, input int unsigned b, input bit v);
    fault_en[a] = 1'b1; fault_bit[a] = b; fault_val[a] = v;
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge
  task automatic issue_start(input bit p, input bit expect_done);
    pat_sel  = p;
    start    = 1'b1;
    test_pat = p;
    if (expect_done) exp_q.push_back(model(p, cyc));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Scrambles pat_sel during the run; optionally re-pulses start while busy
  task automatic wait_done(input int unsigned repulse_at);
    int unsigned k;
    k = 1;
    while (!done && k < LAT + 20) begin
      start   = (k == repulse_at);
      pat_sel = 1'($urandom);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got done=0 expected done=1 within %0d cycles", LAT + 20);
    end
  endtask

  task automatic check_cleared_after_start();
    check("b2b_done_drop", 64'(done), 64'(0));
    check("b2b_err_clear", 64'(err_count), 64'(0));
    check("b2b_busy", 64'(busy), 64'(1));
`ifdef MEM_BIST_ERR_LOG_EN
    check("b2b_log_clear", 64'(first_err_valid), 64'(0));
`endif
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: got no completion expected finish before %0d cycles", 60000);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    rst = 1'b1; start = 1'b0; pat_sel = 1'b0;
    clear_faults();
    for (int unsigned a = 0; a < DEPTH; a++) mem[a] = '0;
    repeat (3) @(negedge clk);
    check("rst_ram_cs", 64'(ram_cs), 64'(0));
    check("rst_ram_wr", 64'(ram_wr), 64'(0));
    check("rst_ram_addr", 64'(ram_addr), 64'(0));
    check("rst_ram_data_in", 64'(ram_data_in), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_pass", 64'(pass), 64'(0));
    check("rst_err_count", 64'(err_count), 64'(0));

    // Fault-free, pattern 0, start on the first edge after reset release
    rst = 1'b0;
    issue_start(1'b0, 1'b1);
    wait_done(0);
    check("mem3_pat0", 64'(mem[3]), 64'h06);
    check("mem200_pat0", 64'(mem[200]), 64'h90);

    // Back-to-back, inverted pattern
    issue_start(1'b1, 1'b1);
    check_cleared_after_start();
    wait_done(0);
    check("mem3_pat1", 64'(mem[3]), 64'hF9);

    // Stuck-at-1 on bit 0 of address 5, start re-pulsed mid-test
    add_fault(5, 0, 1'b1);
    issue_start(1'b0, 1'b1);
    check_cleared_after_start();
    wait_done(99);
    clear_faults();

    // Reset during WRITE at address 300, then a full test
    @(negedge clk);
    issue_start(1'($urandom), 1'b0);
    k = 0;
    while (!(ram_wr && ram_addr == ADDR_W'(300)) && k < DEPTH) begin
      @(negedge clk); k++;
    end
    check("abort_reached_addr300", 64'(ram_addr), 64'(300));
    #2 rst = 1'b1;
    #1;
    check("abort_ram_wr", 64'(ram_wr), 64'(0));
    check("abort_ram_cs", 64'(ram_cs), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_ram_addr", 64'(ram_addr), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    add_fault($urandom_range(0, DEPTH - 1), $urandom_range(0, WORD_W - 1), 1'($urandom));
    issue_start(1'($urandom), 1'b1);
    wait_done(0);

    // Randomized patterns and fault sets, back-to-back
    for (int t = 0; t < 4; t++) begin
      clear_faults();
      for (int f = 0; f < int'($urandom_range(0, 3)); f++)
        add_fault($urandom_range(0, DEPTH - 1), $urandom_range(0, WORD_W - 1), 1'($urandom));
      issue_start(1'($urandom), 1'b1);
      check_cleared_after_start();
      wait_done(0);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
